id_ex_pipe_stage: RTL and testbench

//  Parametrised ID->EX pipeline stage register with valid/ready handshake, flush and bubble insertion.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_slot.sv | 60 ++++++
 rtl/id_ex_pipe_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID->EX pipeline stage.
//   - Default payload widths (control and data fields).
//   - Bit offsets of every control signal inside the control word.
//   - Bit offsets of every data field inside the data word.
//   - CTRL_BUBBLE: the control word that turns a slot into a no-op.
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 154;

  // Control word bit positions.
  localparam int CTRL_REGWRITE     = 0;
  localparam int CTRL_BRANCH       = 1;
  localparam int CTRL_ALUSRC       = 2;
  localparam int CTRL_MEMWRITE     = 3;
  localparam int CTRL_MEMREAD      = 4;
  localparam int CTRL_LOADDIV_LSB  = 5;   // 7:5
  localparam int CTRL_STOREDIV_LSB = 8;   // 9:8
  localparam int CTRL_ALUOP_LSB    = 10;  // 11:10
  localparam int CTRL_MEMTOREG_LSB = 12;  // 13:12
  localparam int CTRL_REGDST_LSB   = 14;  // 15:14

  // Data word field LSBs, pc in the top 32 bits down to funct at bit 0.
  localparam int DATA_FUNCT_LSB   = 0;    // 6 bits
  localparam int DATA_SA_LSB      = 6;    // 5 bits
  localparam int DATA_RS_LSB      = 11;   // 5 bits
  localparam int DATA_RD_LSB      = 16;   // 5 bits
  localparam int DATA_RT_LSB      = 21;   // 5 bits
  localparam int DATA_IMM_LSB     = 26;   // 32 bits
  localparam int DATA_RT_DATA_LSB = 58;   // 32 bits
  localparam int DATA_RS_DATA_LSB = 90;   // 32 bits
  localparam int DATA_PC_LSB      = 122;  // 32 bits

  // All control bits low: no register write, no memory access, no branch.
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag + control word + data word.
//   clk, rst_n : clock, synchronous active-low reset (clears everything)
//   load       : capture ld_ctrl/ld_data and mark the slot valid
//   clear      : drop the slot (valid=0, ctrl=bubble), data is held
//   ld_ctrl    : control word to capture
//   ld_data    : data word to capture
//   valid/ctrl/data : registered slot contents
// clear wins over load if both are asserted.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
  logic [DATA_W-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_W'(CTRL_BUBBLE);
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage register with handshake, flush and bubble insertion.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : squash stage contents; nothing is accepted that cycle
//   in_valid/in_ready   : decode-side handshake
//   in_ctrl/in_data     : decode payload
//   out_valid/out_ready : EX-side handshake
//   out_ctrl            : registered control word, 0 whenever out_valid=0
//   out_data            : registered data word, held across bubbles
//   stall_cycles        : saturating count of cycles with out_valid && !out_ready
//
// Handshake: a payload moves across a port on every rising edge where that
// port's valid and ready are both high. valid never depends on ready on the
// same port; in_ready is low during reset and during flush.
//
// Build option PIPE_SKID_EN adds a second (skid) slot so that in_ready is
// registered-only (no combinational path from out_ready). Without it the stage
// holds a single slot and in_ready follows out_ready combinationally.
module id_ex_pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic              main_valid;
  logic              main_load, main_clear;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;
  logic              in_xfer, out_xfer;

  assign out_xfer = main_valid && out_ready;
  assign in_xfer  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic              skid_load, skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = rst_n && !flush && !skid_valid;

  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    main_ld_ctrl = in_ctrl;
    main_ld_data = in_data;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_valid) begin
      // in_ready is low here, so the only movement is skid -> main.
      if (out_xfer) begin
        main_load    = 1'b1;
        main_ld_ctrl = skid_ctrl;
        main_ld_data = skid_data;
        skid_clear   = 1'b1;
      end
    end else if (in_xfer) begin
      // Main is busy and not draining: park the new payload in the skid.
      if (main_valid && !out_ready) skid_load = 1'b1;
      else                          main_load = 1'b1;
    end else if (out_xfer) begin
      main_clear = 1'b1;
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );
`else
  assign in_ready = rst_n && !flush && (!main_valid || out_ready);

  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    main_ld_ctrl = in_ctrl;
    main_ld_data = in_data;
    if (flush)         main_clear = 1'b1;
    else if (in_xfer)  main_load  = 1'b1;  // also covers replace-on-drain
    else if (out_xfer) main_clear = 1'b1;  // bubble
  end
`endif

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .clear   (main_clear),
    .ld_ctrl (main_ld_ctrl),
    .ld_data (main_ld_data),
    .valid   (main_valid),
    .ctrl    (out_ctrl),
    .data    (out_data)
  );

  assign out_valid = main_valid;

  // Stall counter: saturates at all-ones, survives flush.
  logic [CNT_W-1:0] stall_d, stall_q;

  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage. The reference is a FIFO of payloads with a
// capacity of 1 (2 when PIPE_SKID_EN is defined); outputs are derived from
// the head of that FIFO and the stall counter is tracked arithmetically.
module tb_id_ex_pipe_stage;
  import pipe_pkg::*;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 154;
  localparam int CNT_W  = 4;
  localparam int PW     = CTRL_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  stall_cycles;

  // Clock / reset: reset is driven through the step task.
  always #5 clk = ~clk;

  id_ex_pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
    .stall_cycles (stall_cycles)
  );

  // Scoreboard / reference model state.
  logic [PW-1:0]     exp_q[$];
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  m_cnt;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [159:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[DATA_W-1:0];
  endfunction

  // One clock cycle: drive at the falling edge, check in_ready before the
  // rising edge, advance the model at the edge, check outputs 1 ns after.
  task automatic step(input logic rn, input logic fl, input logic iv,
                      input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                      input logic orr);
    logic          m_ready, m_ov;
    logic [PW-1:0] head;
    rst_n = rn; flush = fl; in_valid = iv; in_ctrl = ic; in_data = id;
    out_ready = orr;
    #1;
    m_ov    = (exp_q.size() > 0);
    m_ready = rn && !fl && ((exp_q.size() < CAP) || (CAP == 1 && orr));
    check("in_ready", DATA_W'(in_ready), DATA_W'(m_ready));
    @(posedge clk);
    if (!rn) begin
      exp_q.delete();
      m_data = '0;
      m_cnt  = '0;
    end else begin
      if (m_ov && !orr && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
      if (fl) exp_q.delete();
      else begin
        if (m_ov && orr)  void'(exp_q.pop_front());
        if (iv && m_ready) exp_q.push_back({ic, id});
        if (exp_q.size() > 0) begin
          head   = exp_q[0];
          m_data = head[DATA_W-1:0];
        end
      end
    end
    #1;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("out_valid", DATA_W'(out_valid), DATA_W'(exp_q.size() > 0));
    check("out_ctrl", DATA_W'(out_ctrl), DATA_W'(head[PW-1:DATA_W]));
    check("out_data", out_data, m_data);
    check("stall_cycles", DATA_W'(stall_cycles), DATA_W'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    logic [DATA_W-1:0] pc_data;
    logic [DATA_W-1:0] held;
    m_data = '0;
    m_cnt  = '0;

    // Reset.
    step(0, 0, 0, '0, '0, 0);
    step(0, 0, 1, 16'hFFFF, rand_data(), 1);

    // 1: single payload, one-cycle latency.
    pc_data = '0;
    pc_data[DATA_PC_LSB +: 32] = 32'h0040_0010;
    step(1, 0, 1, 16'hA5C3, pc_data, 1);
    check("t1_ctrl", DATA_W'(out_ctrl), DATA_W'(16'hA5C3));
    check("t1_pc", DATA_W'(out_data[DATA_PC_LSB +: 32]), DATA_W'(32'h0040_0010));
    step(1, 0, 0, '0, '0, 1);

    // 2: eight back-to-back payloads.
    for (int i = 0; i < 8; i++)
      step(1, 0, 1, CTRL_W'($urandom()), rand_data(), 1);
    step(1, 0, 0, '0, '0, 1);

    // 3: hold a payload for 5 stalled cycles while decode keeps offering.
    step(1, 0, 1, 16'h1234, rand_data(), 1);
    held = out_data;
    for (int i = 0; i < 5; i++)
      step(1, 0, 1, CTRL_W'($urandom()), rand_data(), 0);
    check("t3_stall5", DATA_W'(stall_cycles), DATA_W'(5));
    check("t3_ctrl_stable", DATA_W'(out_ctrl), DATA_W'(16'h1234));
    check("t3_data_stable", out_data, held);

    // 4: flush with a full stage and a payload on the input.
    held = out_data;
    step(1, 1, 1, 16'hDEAD, rand_data(), 0);
    check("t4_data_held", out_data, held);
    step(1, 0, 0, '0, '0, 1);
    step(1, 0, 0, '0, '0, 1);

    // 5: reach 7 stalled cycles, then reset mid-stall.
    step(1, 0, 1, CTRL_W'($urandom()), rand_data(), 0);
    for (int i = 0; i < 10 && m_cnt < 7; i++)
      step(1, 0, 0, '0, '0, 0);
    check("t5_stall7", DATA_W'(stall_cycles), DATA_W'(7));
    step(0, 0, 1, CTRL_W'($urandom()), rand_data(), 0);
    check("t5_rst_stall", DATA_W'(stall_cycles), DATA_W'(0));
    step(1, 0, 0, '0, '0, 0);

    // 6: saturate the 4-bit counter and stall once more.
    step(1, 0, 1, 16'h0F0F, rand_data(), 0);
    for (int i = 0; i < 16; i++)
      step(1, 0, 0, '0, '0, 0);
    check("t6_saturate", DATA_W'(stall_cycles), DATA_W'(4'hF));
    step(0, 0, 0, '0, '0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)), CTRL_W'($urandom()), rand_data(),
           ($urandom_range(0, 2) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
